// File: rtl/risc_pkg.sv
// risc_pkg
//   Shared constants and types for the risc memory subsystem.
//   - REQ_FETCH / REQ_DATA / REQ_LOADER : default requester slots on the
//     unified-memory arbiter (instruction fetch, LD/ST stage, debug loader).
//   - MEM_AW / MEM_DW : geometry of the 1024x16 unified memory.
//   - arb_state_t : burst-lock state of the memory arbiter.
package risc_pkg;

    localparam int REQ_FETCH  = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_LOADER = 2;

    localparam int MEM_AW = 10;
    localparam int MEM_DW = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/risc_mem_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Purely combinational rotating-priority picker. Searches req upward from
//   index 'start' (modulo N) and returns the first requester found.
//   Ports:
//     req   in  N   request vector
//     start in  PW  index with highest priority this cycle
//     gnt   out N   one-hot pick, all zero when nothing requests
//     idx   out PW  encoded index of the pick (0 when nothing requests)
//     any   out 1   at least one request present
module rr_priority_pick
    import risc_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int p;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 0; k < N; k++) begin
            p = (int'(start) + k) % N;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = PW'(p);
            end
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter
//   Shares the single-port unified memory between NREQ requesters with
//   round-robin fairness, an optional bounded burst lock, and a registered
//   read-valid return path. The command is issued combinationally in the
//   grant cycle; read data comes back from the memory one cycle later.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     req/lock/we  [NREQ] per-requester request, burst lock, write enable
//     addr  [NREQ*AW]     packed addresses, requester i at [i*AW +: AW]
//     wdata [NREQ*DW]     packed write data, requester i at [i*DW +: DW]
//     gnt    [NREQ]       one-hot combinational grant
//     rvalid [NREQ]       one-hot registered read-data valid
//     rdata  [DW]         shared read data, qualified by rvalid
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [3:0]      burst_cnt, burst_cnt_nxt;

    logic [NREQ-1:0] pick_gnt, gnt_raw;
    logic [PW-1:0]   pick_idx, gidx;
    logic            pick_any, lock_hold, any_gnt;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_priority_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .start (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The burst owner keeps the port only while it still requests with lock
    // asserted; otherwise the round-robin pick takes over in the same cycle.
    assign lock_hold = (state == ARB_BURST) && req[owner] && lock[owner];
    assign gidx      = lock_hold ? owner : pick_idx;
    assign gnt_raw   = lock_hold ? (NREQ'(1) << owner) : pick_gnt;

    // Grant is gated by reset so the memory strobe drops the instant rst_n falls.
    assign gnt     = rst_n ? gnt_raw : '0;
    assign any_gnt = |gnt;

    assign mem_en    = any_gnt;
    assign mem_we    = any_gnt & we[gidx];
    assign mem_addr  = addr[gidx*AW +: AW];
    assign mem_wdata = wdata[gidx*DW +: DW];
    assign rdata     = mem_rdata;

    always_comb begin
        state_nxt     = ARB_IDLE;
        rr_ptr_nxt    = rr_ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = '0;
        if (lock_hold) begin
            // Continuation grant: pointer frozen unless the burst cap is hit.
            if (burst_cnt == 4'(MAX_BURST - 1)) begin
                rr_ptr_nxt = wrap_inc(owner);
            end else begin
                state_nxt     = ARB_BURST;
                burst_cnt_nxt = burst_cnt + 1'b1;
            end
        end else if (any_gnt) begin
            rr_ptr_nxt = wrap_inc(gidx);
            if (lock[gidx] && (MAX_BURST > 1)) begin
                state_nxt     = ARB_BURST;
                owner_nxt     = gidx;
                burst_cnt_nxt = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            rvalid    <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            // Memory read latency is exactly one cycle, so the valid is
            // the grant of a read, delayed by one register.
            rvalid    <= (any_gnt && !we[gidx]) ? gnt : '0;
        end
    end

endmodule
